// File: rtl/ram_access_ctrl.sv
// Registered load/store sequencer in front of the 64x16 gate-level RAM.
// Optional MEM_CLEAR_EN: zero-fill sweep of the whole RAM after every reset.
module ram_access_ctrl #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic          REQ_WE,
  input  logic [AW-1:0] REQ_ADDR,
  input  logic [DW-1:0] REQ_WDATA,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [DW-1:0] RSP_RDATA,
  output logic          BUSY,
  output logic [DW-1:0] MEM_D,
  output logic          MEM_W,
  output logic          MEM_R,
  output logic          MEM_E,
  output logic [AW-1:0] MEM_ADDR,
  input  logic [DW-1:0] MEM_Q
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_RSP  = 3'd3
`ifdef MEM_CLEAR_EN
    , S_INIT = 3'd4
`endif
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_busy;
  logic [DW-1:0] r_mem_d;
  logic          r_mem_w;
  logic          r_mem_r;
  logic          r_mem_e;
  logic [AW-1:0] r_mem_addr;

  logic          w_req_ready;
  logic          w_rsp_valid;
  logic          w_busy;
  logic [DW-1:0] w_mem_d;
  logic          w_mem_w;
  logic          w_mem_r;
  logic          w_mem_e;
  logic [AW-1:0] w_mem_addr;

`ifdef MEM_CLEAR_EN
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt;
`endif

  // Output registers are loaded with the levels of the state being entered,
  // so every pin is a clean flop output with no path from REQ_*/RSP_READY.
  always_comb begin
    w_nxt       = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_busy      = 1'b1;
    w_mem_d     = r_mem_d;
    w_mem_w     = 1'b0;
    w_mem_r     = 1'b0;
    w_mem_e     = 1'b0;
    w_mem_addr  = r_mem_addr;
`ifdef MEM_CLEAR_EN
    w_cnt       = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (REQ_VALID && r_req_ready) begin
          w_mem_addr = REQ_ADDR;
          w_mem_d    = REQ_WDATA;
          w_mem_e    = 1'b1;
          if (REQ_WE) begin
            w_nxt   = S_WR;
            w_mem_w = 1'b1;
          end else begin
            w_nxt   = S_RD;
            w_mem_r = 1'b1;
          end
        end else begin
          w_req_ready = 1'b1;
          w_busy      = 1'b0;
        end
      end
      S_WR: begin
        w_nxt       = S_IDLE;
        w_req_ready = 1'b1;
        w_busy      = 1'b0;
      end
      S_RD: begin
        w_nxt       = S_RSP;
        w_rsp_valid = 1'b1;
      end
      S_RSP: begin
        if (RSP_READY) begin
          w_nxt       = S_IDLE;
          w_req_ready = 1'b1;
          w_busy      = 1'b0;
        end else begin
          w_rsp_valid = 1'b1;
        end
      end
`ifdef MEM_CLEAR_EN
      // One zero write per cycle; the final write's levels stay on the pins
      // for one cycle after the state has already returned to IDLE.
      S_INIT: begin
        w_mem_e    = 1'b1;
        w_mem_w    = 1'b1;
        w_mem_d    = {DW{1'b0}};
        w_mem_addr = r_cnt;
        w_cnt      = r_cnt + {{(AW-1){1'b0}}, 1'b1};
        if (r_cnt == {AW{1'b1}}) begin
          w_nxt = S_IDLE;
        end else begin
          w_nxt = S_INIT;
        end
      end
`endif
      default: begin
        w_nxt       = S_IDLE;
        w_req_ready = 1'b1;
        w_busy      = 1'b0;
      end
    endcase
  end

  // State, output and load-data registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
`ifdef MEM_CLEAR_EN
      r_state     <= S_INIT;
      r_req_ready <= 1'b0;
      r_cnt       <= {AW{1'b0}};
`else
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
`endif
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DW{1'b0}};
      r_busy      <= 1'b0;
      r_mem_d     <= {DW{1'b0}};
      r_mem_w     <= 1'b0;
      r_mem_r     <= 1'b0;
      r_mem_e     <= 1'b0;
      r_mem_addr  <= {AW{1'b0}};
    end else begin
      r_state     <= w_nxt;
      r_req_ready <= w_req_ready;
      r_rsp_valid <= w_rsp_valid;
      r_busy      <= w_busy;
      r_mem_d     <= w_mem_d;
      r_mem_w     <= w_mem_w;
      r_mem_r     <= w_mem_r;
      r_mem_e     <= w_mem_e;
      r_mem_addr  <= w_mem_addr;
`ifdef MEM_CLEAR_EN
      r_cnt       <= w_cnt;
`endif
      // MEM_Q is only meaningful while MEM_R is high, i.e. during RD.
      if (r_state == S_RD) begin
        r_rsp_rdata <= MEM_Q;
      end else begin
        r_rsp_rdata <= r_rsp_rdata;
      end
    end
  end

  assign REQ_READY = r_req_ready;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_RDATA = r_rsp_rdata;
  assign BUSY      = r_busy;
  assign MEM_D     = r_mem_d;
  assign MEM_W     = r_mem_w;
  assign MEM_R     = r_mem_r;
  assign MEM_E     = r_mem_e;
  assign MEM_ADDR  = r_mem_addr;

endmodule
